// File: rtl/mac_pkg.sv
// Shared types and defaults for the approximate-MAC job sequencer.
// Holds the FSM state encoding and the datapath widths.
package mac_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int AW_DEFAULT    = 2 * DW_DEFAULT;
    localparam int LEN_W_DEFAULT = 8;

    localparam logic [3:0] TRUNC_EXACT = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Job, operand, multiplier and result signals of the MAC job sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface mac_job_sequencer_if
    import mac_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) ();

    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic [3:0]       job_trunc;
    logic             abort;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;

    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic [3:0]       mul_trunc;
    logic [AW-1:0]    mul_prod;

    logic             res_valid;
    logic             res_ready;
    logic [AW-1:0]    res_data;
    logic             res_ovf;

    logic             busy;

    modport slave (
        input  job_valid, job_len, job_trunc, abort,
        input  in_valid, in_a, in_b,
        input  mul_prod,
        input  res_ready,
        output job_ready, in_ready,
        output mul_a, mul_b, mul_trunc,
        output res_valid, res_data, res_ovf,
        output busy
    );

    modport master (
        output job_valid, job_len, job_trunc, abort,
        output in_valid, in_a, in_b,
        output mul_prod,
        output res_ready,
        input  job_ready, in_ready,
        input  mul_a, mul_b, mul_trunc,
        input  res_valid, res_data, res_ovf,
        input  busy
    );

endinterface

// File: rtl/mac_acc_reg.sv
// Wrap-around accumulator with a sticky carry-out flag.
// A synchronous clear takes priority over an accumulate enable.
module mac_acc_reg
    import mac_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [AW-1:0] addend_i,
    output logic [AW-1:0] acc_o,
    output logic          ovf_o
);

    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   sum;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, addend_i};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            acc_d = sum[AW-1:0];
            ovf_d = ovf_q | sum[AW];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_job_sequencer.sv
// Sequences dot-product jobs: accepts a job, streams operand pairs through the
// external multiplier, accumulates the products and returns one result per job.
module mac_job_sequencer
    import mac_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mac_job_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [3:0]       trunc_q, trunc_d;

    logic             job_fire;
    logic             pair_fire;
    logic             abort_act;
    logic             acc_clr;
    logic [AW-1:0]    acc;
    logic             acc_ovf;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;

    // Abort outranks both a pair accept and the result handshake.
    assign abort_act = bus.abort && (state_q != ST_IDLE);
    assign job_fire  = bus.job_valid && (state_q == ST_IDLE);
    assign pair_fire = bus.in_valid && (state_q == ST_RUN) && !bus.abort;
    assign acc_clr   = job_fire || abort_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (job_fire) begin
                    state_d = (bus.job_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_act) begin
                    state_d = ST_IDLE;
                end else if (pair_fire && (count_q == LEN_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort_act || bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.job_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                bus.job_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            ST_RUN:  bus.in_ready  = 1'b1;
            ST_DONE: bus.res_valid = 1'b1;
            default: bus.busy      = 1'b1;
        endcase
    end

    // Remaining-pair counter and the truncation mode held for the whole job.
    always_comb begin
        count_d = count_q;
        trunc_d = trunc_q;
        if (job_fire) begin
            count_d = bus.job_len;
            trunc_d = bus.job_trunc;
        end else if (abort_act) begin
            count_d = '0;
        end else if (pair_fire) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            trunc_q <= TRUNC_EXACT;
        end else begin
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    mac_acc_reg #(.AW(AW)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (acc_clr),
        .en_i     (pair_fire),
        .addend_i (bus.mul_prod),
        .acc_o    (acc),
        .ovf_o    (acc_ovf)
    );

    assign op_a          = bus.in_a;
    assign op_b          = bus.in_b;
    assign bus.mul_a     = op_a;
    assign bus.mul_b     = op_b;
    assign bus.mul_trunc = trunc_q;
    assign bus.res_data  = acc;
    assign bus.res_ovf   = acc_ovf;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Self-checking bench for mac_job_sequencer: directed scenarios plus random jobs
// checked against a sum-of-products reference model.
module tb_mac_job_sequencer;
    import mac_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [DW-1:0] pa[$];
    logic [DW-1:0] pb[$];
    bit            vpat[$];

    mac_job_sequencer_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

    mac_job_sequencer #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: exact product with the low bits selected by trunc forced to zero.
    function automatic logic [AW-1:0] approx_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                  input logic [3:0] t);
        logic [AW-1:0] p;
        p = AW'(a) * AW'(b);
        return p & ~AW'(t);
    endfunction

    assign bus.mul_prod = approx_mul(bus.mul_a, bus.mul_b, bus.mul_trunc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input int len, input logic [3:0] tr, input string tag);
        bus.job_valid = 1'b1;
        bus.job_len   = LEN_W'(len);
        bus.job_trunc = tr;
        vectors++;
        if (bus.job_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_job_ready: got %b need 1", tag, bus.job_ready);
        end
        step();
        bus.job_valid = 1'b0;
        bus.job_trunc = 4'($urandom);
    endtask

    // Feeds the queued pairs; the expected result is the plain sum of products.
    task automatic feed_pairs(input logic [3:0] tr, input string tag, input bit expect_done,
                              output logic [AW-1:0] exp_data, output logic exp_ovf);
        longint total;
        int     budget;
        bit     v;
        total  = 0;
        budget = 0;
        while (pa.size() > 0 && budget < 1000) begin
            v = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
            bus.in_valid = v;
            bus.in_a     = pa[0];
            bus.in_b     = pb[0];
            #1;
            vectors++;
            if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_run: in_ready=%b res_valid=%b need 1/0", tag, bus.in_ready, bus.res_valid);
            end
            vectors++;
            if (bus.mul_trunc !== tr || bus.mul_a !== pa[0] || bus.mul_b !== pb[0]) begin
                miscompares++;
                $display("FAIL %s_mul_if: trunc=%h a=%0d b=%0d need %h %0d %0d",
                         tag, bus.mul_trunc, bus.mul_a, bus.mul_b, tr, pa[0], pb[0]);
            end
            step();
            if (v) begin
                total += longint'((int'(pa[0]) * int'(pb[0])) & ~int'(tr));
                void'(pa.pop_front());
                void'(pb.pop_front());
            end
            budget++;
        end
        bus.in_valid = 1'b0;
        if (pa.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d pairs left need 0", tag, pa.size());
            pa.delete();
            pb.delete();
        end
        vpat.delete();
        exp_data = total[AW-1:0];
        exp_ovf  = (total > 65535);
        if (expect_done) begin
            vectors++;
            if (bus.res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_latency: res_valid=%b need 1", tag, bus.res_valid);
            end
        end
    endtask

    // Holds res_ready low for 'hold' cycles while a job request is pending, then hands shakes.
    task automatic take_result(input int hold, input logic [AW-1:0] exp_data, input logic exp_ovf,
                               input string tag);
        bus.job_valid = 1'b1;
        bus.job_len   = '0;
        for (int i = 0; i <= hold; i++) begin
            bus.res_ready = (i == hold);
            #1;
            vectors++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data || bus.res_ovf !== exp_ovf) begin
                miscompares++;
                $display("FAIL %s_result: valid=%b data=%0d ovf=%b need 1 %0d %b",
                         tag, bus.res_valid, bus.res_data, bus.res_ovf, exp_data, exp_ovf);
            end
            vectors++;
            if (bus.job_ready !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_done_flags: job_ready=%b in_ready=%b busy=%b need 0 0 1",
                         tag, bus.job_ready, bus.in_ready, bus.busy);
            end
            step();
        end
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b0;
        vectors++;
        if (bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_back_idle: job_ready=%b res_valid=%b busy=%b need 1 0 0",
                     tag, bus.job_ready, bus.res_valid, bus.busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (bus.job_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.res_ovf !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_flags: job_ready=%b in_ready=%b res_valid=%b ovf=%b busy=%b need 1 0 0 0 0",
                     tag, bus.job_ready, bus.in_ready, bus.res_valid, bus.res_ovf, bus.busy);
        end
        vectors++;
        if (bus.res_data !== '0 || bus.mul_trunc !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s_data: res_data=%0d mul_trunc=%h need 0 0", tag, bus.res_data, bus.mul_trunc);
        end
    endtask

    task automatic test_reset();
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        bus.job_trunc = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        logic [AW-1:0] d;
        logic          o;
        accept_job(3, 4'b0000, "basic");
        pa = '{8'd2, 8'd4, 8'd10};
        pb = '{8'd3, 8'd5, 8'd10};
        feed_pairs(4'b0000, "basic", 1'b1, d, o);
        take_result(0, d, o, "basic");
    endtask

    task automatic test_empty_job();
        accept_job(0, 4'b0101, "empty");
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_latency: res_valid=%b in_ready=%b need 1 0", bus.res_valid, bus.in_ready);
        end
        take_result(1, 16'd0, 1'b0, "empty");
    endtask

    task automatic test_wrap();
        logic [AW-1:0] d;
        logic          o;
        accept_job(2, 4'b0000, "wrap");
        pa = '{8'd255, 8'd255};
        pb = '{8'd255, 8'd255};
        feed_pairs(4'b0000, "wrap", 1'b1, d, o);
        take_result(0, d, o, "wrap");
    endtask

    task automatic test_stall();
        logic [AW-1:0] d;
        logic          o;
        accept_job(4, 4'b0010, "stall");
        for (int i = 0; i < 4; i++) begin
            pa.push_back(8'($urandom));
            pb.push_back(8'($urandom));
        end
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        feed_pairs(4'b0010, "stall", 1'b1, d, o);
        take_result(5, d, o, "stall");
    endtask

    task automatic test_abort();
        logic [AW-1:0] d;
        logic          o;
        accept_job(4, 4'b0000, "abort");
        pa = '{8'd11, 8'd12};
        pb = '{8'd13, 8'd14};
        feed_pairs(4'b0000, "abort", 1'b0, d, o);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd9;
        bus.in_b     = 8'd9;
        bus.abort    = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_idle: job_ready=%b busy=%b res_valid=%b in_ready=%b need 1 0 0 0",
                         bus.job_ready, bus.busy, bus.res_valid, bus.in_ready);
            end
            step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        vectors++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_idle: job_ready=%b busy=%b need 1 0", bus.job_ready, bus.busy);
        end
        accept_job(1, 4'b0000, "after_abort");
        pa = '{8'd7};
        pb = '{8'd6};
        feed_pairs(4'b0000, "after_abort", 1'b1, d, o);
        take_result(0, d, o, "after_abort");
    endtask

    task automatic test_reset_mid_job();
        logic [AW-1:0] d;
        logic          o;
        accept_job(5, 4'b0110, "midrst");
        pa = '{8'd200, 8'd201};
        pb = '{8'd250, 8'd251};
        feed_pairs(4'b0110, "midrst", 1'b0, d, o);
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check_reset_values("midrst_after");
        accept_job(3, 4'b1111, "trunc15");
        for (int i = 0; i < 3; i++) begin
            pa.push_back(8'($urandom));
            pb.push_back(8'($urandom));
        end
        feed_pairs(4'b1111, "trunc15", 1'b1, d, o);
        vectors++;
        if (bus.mul_trunc !== 4'b1111) begin
            miscompares++;
            $display("FAIL trunc15_hold: mul_trunc=%h need f", bus.mul_trunc);
        end
        take_result(1, d, o, "trunc15");
    endtask

    task automatic test_long_job();
        logic [AW-1:0] d;
        logic          o;
        accept_job(255, 4'b0000, "long");
        for (int i = 0; i < 255; i++) begin
            pa.push_back(8'd255);
            pb.push_back(8'd255);
        end
        feed_pairs(4'b0000, "long", 1'b1, d, o);
        take_result(0, d, o, "long");
    endtask

    task automatic test_random_jobs();
        logic [AW-1:0] d;
        logic          o;
        logic [3:0]    tr;
        int            len;
        for (int j = 0; j < 25; j++) begin
            len = int'($urandom_range(0, 12));
            tr  = 4'($urandom);
            accept_job(len, tr, "rand");
            for (int i = 0; i < len; i++) begin
                pa.push_back(8'($urandom));
                pb.push_back(8'($urandom));
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) vpat.push_back(1'b0);
                vpat.push_back(1'b1);
            end
            feed_pairs(tr, "rand", 1'b1, d, o);
            take_result(int'($urandom_range(0, 3)), d, o, "rand");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_empty_job();
        test_wrap();
        test_stall();
        test_abort();
        test_reset_mid_job();
        test_long_job();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
